// File: rtl/ttt_pkg.sv
// ttt_pkg: shared tic-tac-toe cell codes, line/preference tables, AI state enum and board helpers
package ttt_pkg;
  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] UNUSED = 2'b01;
  localparam logic [1:0] P1 = 2'b10;
  localparam logic [1:0] P2 = 2'b11;
  localparam logic [3:0] LINES [8][3] = '{
    '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
    '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
    '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
  };
  localparam logic [3:0] PREF_ORDER [9] = '{4'd4, 4'd0, 4'd2, 4'd6, 4'd8, 4'd1, 4'd3, 4'd5, 4'd7};
  typedef enum logic [2:0] {IDLE, SCAN_WIN, SCAN_BLK, PREF, DONE, FULL} ai_state_t;
  function automatic logic [1:0] cell_of(input logic [17:0] b, input logic [3:0] i);
    return b[{i, 1'b0} +: 2];
  endfunction
  function automatic logic has_empty(input logic [17:0] b);
    logic e;
    e = 1'b0;
    for (int i = 0; i < 9; i++) e = e | (cell_of(b, 4'(i)) == EMPTY);
    return e;
  endfunction
endpackage

// File: rtl/ttt_ai_player_if.sv
// ttt_ai_player_if: move request/answer bus between game FSM (master) and AI player (slave)
//   req, board, move_ack from the game FSM; move_valid, move, no_move, busy from the AI
interface ttt_ai_player_if;
  logic req;
  logic [17:0] board;
  logic move_ack;
  logic move_valid;
  logic [8:0] move;
  logic no_move;
  logic busy;
  modport master (output req, board, move_ack, input move_valid, move, no_move, busy);
  modport slave (input req, board, move_ack, output move_valid, move, no_move, busy);
endinterface

// File: rtl/ttt_line_eval.sv
// ttt_line_eval: flags a line holding two cells of mark plus one empty cell; pos names the empty one
//   a, b, c: line cells in table order; mark: player code; hit, pos[1:0]: result
module ttt_line_eval
  import ttt_pkg::*;
(
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic [1:0] c,
  input  logic [1:0] mark,
  output logic       hit,
  output logic [1:0] pos
);
  logic [1:0] n;
  assign n = {1'b0, a == mark} + {1'b0, b == mark} + {1'b0, c == mark};
  assign hit = n == 2'd2 && (a == EMPTY || b == EMPTY || c == EMPTY);
  assign pos = a == EMPTY ? 2'd0 : b == EMPTY ? 2'd1 : 2'd2;
endmodule

// File: rtl/ttt_ai_player.sv
// ttt_ai_player: computer opponent; snapshots the board and scans win, block, centre, corner, edge
//   clk, rst (async, active-high); bus: slave side of ttt_ai_player_if
module ttt_ai_player
  import ttt_pkg::*;
#(
  parameter logic [1:0] AI_MARK = P2,
  parameter logic [1:0] OPP_MARK = P1
) (
  input logic clk,
  input logic rst,
  ttt_ai_player_if.slave bus
);
  ai_state_t state, state_n;
  logic [17:0] snap, snap_n;
  logic [2:0] idx, idx_n;
  logic [8:0] move_r, move_n;
  logic [3:0] ci0, ci1, ci2, hit_cell, pref_cell;
  logic hit;
  logic [1:0] pos;
  assign ci0 = LINES[idx][0];
  assign ci1 = LINES[idx][1];
  assign ci2 = LINES[idx][2];
  assign hit_cell = pos == 2'd0 ? ci0 : pos == 2'd1 ? ci1 : ci2;
  ttt_line_eval u_eval (
    .a(cell_of(snap, ci0)),
    .b(cell_of(snap, ci1)),
    .c(cell_of(snap, ci2)),
    .mark(state == SCAN_BLK ? OPP_MARK : AI_MARK),
    .hit(hit),
    .pos(pos)
  );
  // Walk the preference order backwards so the earliest empty entry is the last one written.
  always_comb begin
    pref_cell = 4'd4;
    for (int k = 8; k >= 0; k--) if (cell_of(snap, PREF_ORDER[k]) == EMPTY) pref_cell = PREF_ORDER[k];
  end
  always_comb begin
    state_n = state;
    snap_n = snap;
    idx_n = idx;
    move_n = move_r;
    case (state)
      IDLE: if (bus.req) begin
        snap_n = bus.board;
        idx_n = 3'd0;
        state_n = has_empty(bus.board) ? SCAN_WIN : FULL;
      end
      SCAN_WIN, SCAN_BLK: begin
        idx_n = hit || idx == 3'd7 ? 3'd0 : idx + 3'd1;
        move_n = hit ? 9'(1) << hit_cell : move_r;
        state_n = hit ? DONE : idx != 3'd7 ? state : state == SCAN_WIN ? SCAN_BLK : PREF;
      end
      PREF: begin
        move_n = 9'(1) << pref_cell;
        state_n = DONE;
      end
      DONE, FULL: if (bus.move_ack) begin
        move_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      snap <= '0;
      idx <= '0;
      move_r <= '0;
    end else begin
      state <= state_n;
      snap <= snap_n;
      idx <= idx_n;
      move_r <= move_n;
    end
  end
  assign bus.move_valid = state == DONE || state == FULL;
  assign bus.no_move = state == FULL;
  assign bus.busy = state != IDLE;
  assign bus.move = move_r;
endmodule
